// File: rtl/write_back_unit_if.sv
// Bus between the write-back stage and its neighbours: result sources on the
// producer side, head-of-queue write port on the register-file side.
interface write_back_unit_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2
) ();
  localparam int OFF_W  = $clog2(WIDTH / 8);
  localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PEND_W = $clog2(DEPTH) + 1;

  logic [NUM_SRC*WIDTH-1:0] Src_Data;
  logic [SEL_W-1:0]         Src_Sel;
  logic [2:0]               Load_Mode;
  logic [OFF_W-1:0]         Byte_Offset;
  logic [4:0]               Dest_Reg;
  logic                     In_Valid;
  logic                     In_Ready;
  logic                     RF_Write_En;
  logic [4:0]               RF_Write_Addr;
  logic [WIDTH-1:0]         RF_Write_Data;
  logic                     RF_Ready;
  logic                     Align_Error;
  logic [PEND_W-1:0]        Pending;

  modport slave (
    input  Src_Data, Src_Sel, Load_Mode, Byte_Offset, Dest_Reg, In_Valid, RF_Ready,
    output In_Ready, RF_Write_En, RF_Write_Addr, RF_Write_Data, Align_Error, Pending
  );

  modport master (
    output Src_Data, Src_Sel, Load_Mode, Byte_Offset, Dest_Reg, In_Valid, RF_Ready,
    input  In_Ready, RF_Write_En, RF_Write_Addr, RF_Write_Data, Align_Error, Pending
  );
endinterface

// File: rtl/write_back_unit.sv
// MIPS write-back stage: source select, load alignment/extension on the memory
// source, and a small result queue handshaking into the register file.
module write_back_unit #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int MEM_SRC = 1,
  parameter int DEPTH   = 2
) (
  input logic               clk,
  input logic               rst_n,
  write_back_unit_if.slave  bus
);
  localparam int OFF_W  = $clog2(WIDTH / 8);
  localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PEND_W = PTR_W + 1;

  typedef enum logic [2:0] {
    LD_WORD   = 3'd0,
    LD_BYTE_S = 3'd1,
    LD_BYTE_U = 3'd2,
    LD_HALF_S = 3'd3,
    LD_HALF_U = 3'd4
  } load_mode_e;

  logic [WIDTH-1:0]  src_word;
  logic [WIDTH-1:0]  ext_word;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic              is_mem;
  logic              is_half;
  logic              accept;
  logic              push;
  logic              pop;

  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [4:0]        addr_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_sel;
  logic [PEND_W-1:0] count_q, count_d;
  logic              align_q, align_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    src_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.Src_Sel == SEL_W'(i)) src_word = bus.Src_Data[i*WIDTH +: WIDTH];
    end
  end

  assign is_mem    = (int'(bus.Src_Sel) == MEM_SRC);
  assign byte_lane = src_word[{bus.Byte_Offset, 3'b000} +: 8];
  assign half_lane = src_word[{bus.Byte_Offset[OFF_W-1:1], 4'b0000} +: 16];

  always_comb begin
    ext_word = src_word;
    is_half  = 1'b0;
    if (is_mem) begin
      case (load_mode_e'(bus.Load_Mode))
        LD_BYTE_S: ext_word = {{(WIDTH-8){byte_lane[7]}}, byte_lane};
        LD_BYTE_U: ext_word = {{(WIDTH-8){1'b0}}, byte_lane};
        LD_HALF_S: begin
          ext_word = {{(WIDTH-16){half_lane[15]}}, half_lane};
          is_half  = 1'b1;
        end
        LD_HALF_U: begin
          ext_word = {{(WIDTH-16){1'b0}}, half_lane};
          is_half  = 1'b1;
        end
        default:   ext_word = src_word;
      endcase
    end
  end

  assign bus.In_Ready    = (count_q < PEND_W'(DEPTH));
  assign bus.RF_Write_En = (count_q != '0);
  assign accept = bus.In_Valid & bus.In_Ready;
  assign push   = accept & (bus.Dest_Reg != 5'd0);
  assign pop    = bus.RF_Write_En & bus.RF_Ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + PEND_W'(1);
      2'b01:   count_d = count_q - PEND_W'(1);
      default: count_d = count_q;
    endcase
    align_d = align_q | (accept & is_half & bus.Byte_Offset[0]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      align_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      align_q  <= align_d;
    end
  end

  // NOTE: the queue storage is reset because its contents drive the write
  // port directly, and the port must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= ext_word;
      addr_q[wr_ptr_q] <= bus.Dest_Reg;
    end
  end

  // When empty, show the slot just popped so the port holds its last value.
  assign rd_sel            = (count_q == '0) ? rd_ptr_q - PTR_W'(1) : rd_ptr_q;
  assign bus.RF_Write_Addr = addr_q[rd_sel];
  assign bus.RF_Write_Data = data_q[rd_sel];
  assign bus.Align_Error   = align_q;
  assign bus.Pending       = count_q;
endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit: extension modes, source select, back-
// pressure, $0 discard, concurrent push/pop and asynchronous reset.
module tb_write_back_unit;
  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 3;
  localparam int MEM_SRC = 1;
  localparam int DEPTH   = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  write_back_unit_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) bus ();

  write_back_unit #(
    .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .MEM_SRC(MEM_SRC), .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] sel, input logic [2:0] mode,
                       input logic [1:0] off, input logic [4:0] dest);
    bus.Src_Sel     = sel;
    bus.Load_Mode   = mode;
    bus.Byte_Offset = off;
    bus.Dest_Reg    = dest;
    bus.In_Valid    = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.Src_Data    = '0;
    bus.Src_Sel     = '0;
    bus.Load_Mode   = '0;
    bus.Byte_Offset = '0;
    bus.Dest_Reg    = '0;
    bus.In_Valid    = 1'b0;
    bus.RF_Ready    = 1'b0;
    #3;
    check("rst_pending",  32'(bus.Pending), 32'd0);
    check("rst_en",       32'(bus.RF_Write_En), 32'd0);
    check("rst_addr",     32'(bus.RF_Write_Addr), 32'd0);
    check("rst_data",     bus.RF_Write_Data, 32'd0);
    check("rst_align",    32'(bus.Align_Error), 32'd0);
    check("rst_in_ready", 32'(bus.In_Ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();

    // Memory-source extension; RF_Ready high so each step pops and pushes.
    bus.Src_Data[0*WIDTH +: WIDTH] = 32'h1234_5680;
    bus.Src_Data[1*WIDTH +: WIDTH] = 32'h8899_AABB;
    bus.Src_Data[2*WIDTH +: WIDTH] = 32'hCAFE_F00D;
    bus.RF_Ready = 1'b1;
    offer(2'd1, 3'd1, 2'd2, 5'd5);
    check("byte_s_in_ready", 32'(bus.In_Ready), 32'd1);
    step();
    check("byte_s_en",   32'(bus.RF_Write_En), 32'd1);
    check("byte_s_addr", 32'(bus.RF_Write_Addr), 32'd5);
    check("byte_s_data", bus.RF_Write_Data, 32'hFFFF_FF99);
    offer(2'd1, 3'd2, 2'd2, 5'd6);
    step();
    check("byte_u_pending", 32'(bus.Pending), 32'd1);
    check("byte_u_addr",    32'(bus.RF_Write_Addr), 32'd6);
    check("byte_u_data",    bus.RF_Write_Data, 32'h0000_0099);
    offer(2'd1, 3'd3, 2'd0, 5'd8);
    step();
    check("half_s_data",  bus.RF_Write_Data, 32'hFFFF_AABB);
    check("half_s_align", 32'(bus.Align_Error), 32'd0);
    offer(2'd1, 3'd3, 2'd1, 5'd9);
    step();
    check("misalign_addr",  32'(bus.RF_Write_Addr), 32'd9);
    check("misalign_data",  bus.RF_Write_Data, 32'hFFFF_AABB);
    check("misalign_align", 32'(bus.Align_Error), 32'd1);
    offer(2'd1, 3'd4, 2'd2, 5'd10);
    step();
    check("half_u_data",   bus.RF_Write_Data, 32'h0000_8899);
    check("align_sticky",  32'(bus.Align_Error), 32'd1);
    offer(2'd1, 3'd0, 2'd3, 5'd11);
    step();
    check("word_data", bus.RF_Write_Data, 32'h8899_AABB);
    offer(2'd1, 3'd6, 2'd1, 5'd12);
    step();
    check("mode6_word_data", bus.RF_Write_Data, 32'h8899_AABB);

    // Non-memory sources ignore Load_Mode; out-of-range select yields zero.
    offer(2'd0, 3'd1, 2'd2, 5'd13);
    step();
    check("src0_data", bus.RF_Write_Data, 32'h1234_5680);
    offer(2'd2, 3'd3, 2'd1, 5'd14);
    step();
    check("src2_data", bus.RF_Write_Data, 32'hCAFE_F00D);
    offer(2'd3, 3'd0, 2'd0, 5'd15);
    step();
    check("sel_oob_addr", 32'(bus.RF_Write_Addr), 32'd15);
    check("sel_oob_data", bus.RF_Write_Data, 32'd0);
    bus.In_Valid = 1'b0;
    step();
    check("drain_pending", 32'(bus.Pending), 32'd0);
    check("drain_en",      32'(bus.RF_Write_En), 32'd0);

    // Backpressure and full queue.
    bus.RF_Ready = 1'b0;
    bus.Src_Data[0*WIDTH +: WIDTH] = 32'hA1A1_A1A1;
    offer(2'd0, 3'd0, 2'd0, 5'd1);
    step();
    bus.Src_Data[0*WIDTH +: WIDTH] = 32'hA2A2_A2A2;
    offer(2'd0, 3'd0, 2'd0, 5'd2);
    step();
    check("full_pending",  32'(bus.Pending), 32'd2);
    check("full_in_ready", 32'(bus.In_Ready), 32'd0);
    bus.Src_Data[0*WIDTH +: WIDTH] = 32'hA3A3_A3A3;
    offer(2'd0, 3'd0, 2'd0, 5'd3);
    step();
    check("stall_pending", 32'(bus.Pending), 32'd2);
    check("stall_addr",    32'(bus.RF_Write_Addr), 32'd1);
    check("stall_data",    bus.RF_Write_Data, 32'hA1A1_A1A1);
    bus.RF_Ready = 1'b1;
    check("pop_cycle_in_ready", 32'(bus.In_Ready), 32'd0);
    step();
    bus.RF_Ready = 1'b0;
    check("after_pop_pending",  32'(bus.Pending), 32'd1);
    check("after_pop_addr",     32'(bus.RF_Write_Addr), 32'd2);
    check("after_pop_in_ready", 32'(bus.In_Ready), 32'd1);
    step();
    bus.In_Valid = 1'b0;
    check("third_acc_pending", 32'(bus.Pending), 32'd2);
    check("third_acc_addr",    32'(bus.RF_Write_Addr), 32'd2);
    check("third_acc_data",    bus.RF_Write_Data, 32'hA2A2_A2A2);
    bus.RF_Ready = 1'b1;
    step();
    check("order3_addr", 32'(bus.RF_Write_Addr), 32'd3);
    check("order3_data", bus.RF_Write_Data, 32'hA3A3_A3A3);
    step();
    check("bp_drain_pending", 32'(bus.Pending), 32'd0);

    // $0 discard, then concurrent push and pop at Pending=1.
    offer(2'd0, 3'd0, 2'd0, 5'd0);
    check("r0_in_ready", 32'(bus.In_Ready), 32'd1);
    step();
    check("r0_pending", 32'(bus.Pending), 32'd0);
    check("r0_en",      32'(bus.RF_Write_En), 32'd0);
    bus.RF_Ready = 1'b0;
    bus.Src_Data[0*WIDTH +: WIDTH] = 32'hB4B4_B4B4;
    offer(2'd0, 3'd0, 2'd0, 5'd4);
    step();
    check("cc_pre_pending", 32'(bus.Pending), 32'd1);
    bus.RF_Ready = 1'b1;
    bus.Src_Data[0*WIDTH +: WIDTH] = 32'hB7B7_B7B7;
    offer(2'd0, 3'd0, 2'd0, 5'd7);
    step();
    bus.In_Valid = 1'b0;
    check("cc_pending", 32'(bus.Pending), 32'd1);
    check("cc_addr",    32'(bus.RF_Write_Addr), 32'd7);
    check("cc_data",    bus.RF_Write_Data, 32'hB7B7_B7B7);
    step();
    check("cc_drain_pending", 32'(bus.Pending), 32'd0);

    // Asynchronous reset with two entries in flight.
    bus.RF_Ready = 1'b0;
    offer(2'd0, 3'd0, 2'd0, 5'd1);
    step();
    offer(2'd0, 3'd0, 2'd0, 5'd2);
    step();
    bus.In_Valid = 1'b0;
    check("pre_rst_pending", 32'(bus.Pending), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pending",  32'(bus.Pending), 32'd0);
    check("async_rst_en",       32'(bus.RF_Write_En), 32'd0);
    check("async_rst_align",    32'(bus.Align_Error), 32'd0);
    check("async_rst_in_ready", 32'(bus.In_Ready), 32'd1);
    check("async_rst_data",     bus.RF_Write_Data, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_pending", 32'(bus.Pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_back_unit.md
# write_back_unit

Parametrised write-back stage of the multi-cycle MIPS datapath, the successor to the two-way ALU/memory write-data select. It selects one of NUM_SRC result sources, applies sub-word load alignment and sign/zero extension to the memory source, and buffers completed results in a two-entry queue. It presents each result to the register file with a valid/ready handshake. Writes to register $0 are discarded at entry.

## Interface
Parameters:
- WIDTH, 32, datapath width; power of two, ≥ 32
- NUM_SRC, 4, number of result sources (≥ 2)
- MEM_SRC, 1, source index that carries memory load data (load extension applies only to it)
- DEPTH, 2, result queue entries (power of two, ≥ 2)

Ports (OFF_W = log2(WIDTH/8), SEL_W = max(1, clog2(NUM_SRC))):
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Src_Data  in  NUM_SRC*WIDTH  packed sources; source i at bits [i*WIDTH +: WIDTH]
- Src_Sel  in  SEL_W  source select
- Load_Mode  in  3  0 word, 1 byte signed, 2 byte unsigned, 3 half signed, 4 half unsigned, 5–7 treated as word
- Byte_Offset  in  OFF_W  low address bits of the load
- Dest_Reg  in  5  destination register number
- In_Valid  in  1  result offered
- In_Ready  out  1  unit can accept
- RF_Write_En  out  1  head entry valid toward register file
- RF_Write_Addr  out  5  head entry register number
- RF_Write_Data  out  WIDTH  head entry data
- RF_Ready  in  1  register file accepts head this cycle
- Align_Error  out  1  sticky: misaligned halfword load seen
- Pending  out  clog2(DEPTH)+1  occupied entries

## Operation
- Accept = In_Valid & In_Ready. Pop = RF_Write_En & RF_Ready.
- Source select: Src_Sel ≥ NUM_SRC yields all-zero data.
- Extension only when Src_Sel == MEM_SRC; other sources pass unmodified regardless of Load_Mode.
- Byte modes: byte lane Byte_Offset (lane 0 = bits [7:0]); signed replicates bit 7, unsigned zero-fills to WIDTH.
- Half modes: lane Byte_Offset[OFF_W-1:1]; Byte_Offset[0] ignored for data. If Byte_Offset[0]=1 on an accepted half load, Align_Error sets, and the result is still written.
- Word mode: full source, Byte_Offset ignored.
- Dest_Reg == 0: accepted (handshake completes), not enqueued, Pending unchanged, no RF write.
- Queue: circular buffer, write and read pointers wrap modulo DEPTH, FIFO order preserved.
- In_Ready = (Pending < DEPTH). It is combinational from state only; there is no same-cycle pass-through when full, even if Pop occurs that cycle.
- RF_Write_En = (Pending != 0). RF_Write_Addr and RF_Write_Data come from the head entry and remain stable while RF_Write_En=1 & RF_Ready=0.
- Simultaneous accept (non-zero Dest_Reg) and pop: Pending unchanged, both pointers advance.
- Align_Error is cleared only by reset.

## Timing
- Reset (async assert, any cycle): Pending=0, pointers=0, RF_Write_En=0, RF_Write_Addr=0, RF_Write_Data=0, Align_Error=0, In_Ready=1 after reset. Entries in flight are discarded.
- Latency: a result accepted at edge N appears with RF_Write_En=1 in the cycle after edge N, when the queue was empty.
- Throughput: 1 result/cycle sustained when RF_Ready is held high.
- Full (Pending=DEPTH): In_Ready=0. A pop at edge M gives In_Ready=1 in the cycle after M.
- Empty: RF_Write_En=0, RF_Write_Addr/Data hold last-read entry values (don't-care to consumers).
- Reset deassertion is synchronised externally; the block needs no extra cycles.

## Test plan
- Reset mid-operation: fill 2 entries, assert rst_n=0 → Pending=0, RF_Write_En=0, Align_Error=0, In_Ready=1 immediately, asynchronously.
- Byte extension: source MEM_SRC=0x8899AABB, Load_Mode=1, Byte_Offset=2, Dest_Reg=5 → next cycle RF_Write_En=1, Addr=5, Data=0xFFFFFF99. Load_Mode=2 → 0x00000099.
- Half and misalign: 0x8899AABB, Load_Mode=3, Byte_Offset=0 → 0xFFFFAABB. Then Byte_Offset=1 → 0xFFFFAABB and Align_Error=1, which stays 1 thereafter.
- Non-memory source: Src_Sel=0 with data 0x12345680, Load_Mode=1 → Data=0x12345680 unmodified. Src_Sel=NUM_SRC → Data=0.
- Backpressure and full: RF_Ready=0, offer 3 results (regs 1, 2, 3) → first two accepted, In_Ready=0 on the third, Pending=2, head Addr=1 stable. Raise RF_Ready for 1 cycle → Addr=2 next, third accepted, then order 2, 3.
- $0 discard plus concurrent push/pop: Dest_Reg=0 offered → handshake completes, no RF write. With Pending=1 and RF_Ready=1, accept reg 7 → Pending stays 1, and reg 7 is written the following cycle.
